// File: rtl/piso8_tx.sv
// ============================================================================
//  Module      : piso8_tx
//  Description : Parallel-in/serial-out word transmitter with valid/ready load,
//                selectable per-bit hold time (1-4 clocks) and frame/done strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso8_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sdo,
    output logic             frame,
    output logic             done
);

    localparam int c_CW = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST_BIT = c_CW'(WIDTH - 1);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [1:0]       r_hold;
    logic [1:0]       r_holdcnt;
    logic [c_CW-1:0]  r_bitcnt;

    logic             w_frame;
    logic             w_bit_end;
    logic             w_done;
    logic             w_accept;
    logic             w_out_bit;
    logic [WIDTH-1:0] w_shift_next;

    assign w_frame    = (r_state == c_ST_SHIFT);
    assign w_bit_end  = (r_holdcnt == r_hold);
    assign w_done     = w_frame & w_bit_end & (r_bitcnt == c_LAST_BIT);
    assign load_ready = ~w_frame | w_done;
    assign w_accept   = load_valid & load_ready;

    // The output end of the register is fixed; the word always moves toward it.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_out_bit    = r_shift[WIDTH-1];
            assign w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_out_bit    = r_shift[0];
            assign w_shift_next = {1'b0, r_shift[WIDTH-1:1]};
        end
    endgenerate

    assign sdo   = w_frame & w_out_bit;
    assign frame = w_frame;
    assign done  = w_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_shift   <= '0;
            r_hold    <= '0;
            r_holdcnt <= '0;
            r_bitcnt  <= '0;
        end else if (w_accept) begin
            // Accept wins over end-of-word so a done-cycle load continues gap-free.
            r_state   <= c_ST_SHIFT;
            r_shift   <= d;
            r_hold    <= sel;
            r_holdcnt <= '0;
            r_bitcnt  <= '0;
        end else if (w_frame) begin
            if (w_done) begin
                r_state   <= c_ST_IDLE;
                r_shift   <= '0;
                r_holdcnt <= '0;
                r_bitcnt  <= '0;
            end else if (w_bit_end) begin
                r_shift   <= w_shift_next;
                r_bitcnt  <= r_bitcnt + c_CW'(1);
                r_holdcnt <= '0;
            end else begin
                r_holdcnt <= r_holdcnt + 2'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/piso8_tx.md
Name: piso8_tx

Overview:
- Parallel-in/serial-out byte transmitter: the transmit end of the team's 8-bit shift-register datapath.
- Accepts a byte over a valid/ready handshake and shifts it out one bit at a time, with a frame strobe.
- Per-bit hold time is selectable, so the matching serial-in shift register downstream can sample at 1–4 clocks per bit.
- Sits between the byte-wide source logic and the serial link.

Parameters:
WIDTH, 8, data word width in bits (>=2)
MSB_FIRST, 0, 0 = bit 0 transmitted first; 1 = bit WIDTH-1 first

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  reset; asynchronous and active-low
d  input  WIDTH  parallel data to transmit
sel  input  2  bit hold select; each bit is held sel+1 clocks
load_valid  input  1  source has a word on d/sel
load_ready  output  1  block can accept a word this cycle
sdo  output  1  serial data out
frame  output  1  high while a word's bits are on sdo
done  output  1  one-cycle pulse in the final cycle of a word

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, shift reg=0, counters=0, sdo=0, frame=0, done=0. Consequently load_ready=1 once rst_n is released.
- States:
  - IDLE: frame=0, sdo=0.
  - SHIFT: frame=1.
- Accept occurs on a rising edge where load_valid && load_ready.
  - At accept: d is latched into the shift reg and sel into hold_r. Both the bit counter and the hold counter are cleared. State goes to SHIFT.
  - d and sel changes after accept do not affect the word in flight.
- Latency: the first bit appears on sdo, with frame=1, in the cycle after the accept edge.
- Bit timing:
  - Each bit is driven for exactly hold_r+1 cycles.
  - After that, the register shifts toward the output end: right if MSB_FIRST=0, left if 1.
  - The bit counter then increments.
- Word length: exactly WIDTH*(hold_r+1) frame cycles.
- done=1 only in the last cycle of bit WIDTH-1 (registered/decoded from counters, glitch-free to the sampling edge).
- load_ready = (state==IDLE) | done. This is combinational from registered state and never depends on load_valid.
- Accept on the done cycle (back-to-back):
  - The next word starts in the following cycle with no gap.
  - frame stays 1 and state stays SHIFT.
  - The new sel applies to the new word only.
- End of word with no accept in the done cycle: state returns to IDLE; frame and sdo return to 0 in the next cycle.
- load_valid while load_ready=0 is ignored. No data is lost from the in-flight word, and the source must hold its word.
- Counters:
  - The bit counter is clog2(WIDTH) wide.
  - The hold counter is 2 bits wide and compared against hold_r. Neither counter wraps mid-word.
- Reset asserted mid-word: immediate abort. Outputs go to their reset values, no done pulse is produced, and the word is discarded.
- No X propagation: sdo=0 whenever frame=0.

Test Plan:
- Reset, then d=8'hA5, sel=0, MSB_FIRST=0, pulse load_valid 1 cycle:
  - sdo = 1,0,1,0,0,1,0,1 on cycles 1–8 after accept.
  - frame high for 8 cycles.
  - done high in cycle 8 only.
  - load_ready 0 in cycles 1–7.
- d=8'h3C, sel=3: each bit held 4 cycles; frame high 32 cycles; sdo = 0×8, 1×16, 0×8; done in cycle 32.
- Back-to-back with sel=0: d=8'h01, then d=8'h80 offered on the done cycle:
  - 16 consecutive frame cycles.
  - sdo = 1,0×7,0×7,1.
  - Exactly 2 done pulses (cycles 8 and 16).
- During word 8'hFF, hold load_valid=1 with d=8'h00: ignored until the done cycle; the first word is still 8 ones; 8'h00 follows.
- Drop rst_n at cycle 4 of an 8'hFF word:
  - sdo, frame and done go to 0 immediately.
  - load_ready=1 after release; no done pulse.
  - A new word 8'h81 then transmits correctly.
- MSB_FIRST=1, d=8'hC1, sel=1: sdo = 1,1,0,0,0,0,0,1, each bit 2 cycles; done in cycle 16.
